// File: rtl/counter_sequencer.sv
// Programmable interval controller: sequences a prescaled up-counter into
// one-shot or auto-reload intervals, with tick/done/cfg_err single-cycle pulses.
module counter_sequencer #(
    parameter int width     = 8,
    parameter int pre_width = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 en,
    input  logic                 reload,
    input  logic [width-1:0]     period,
    input  logic [pre_width-1:0] prescale,
    output logic [width-1:0]     cnt,
    output logic                 busy,
    output logic                 tick,
    output logic                 done,
    output logic                 cfg_err,
    output logic                 dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [width-1:0]     cnt_one = width'(1);
    localparam logic [pre_width-1:0] pre_one = pre_width'(1);

    state_t               state, state_n;
    logic [width-1:0]     cnt_n;
    logic [pre_width-1:0] pre_cnt, pre_cnt_n;
    logic [width-1:0]     period_r, period_n;
    logic [pre_width-1:0] pre_r, pre_n;
    logic                 reload_r, reload_n;
    logic                 tick_n, done_n, err_n;
    logic [width-1:0]     last_cnt;

    // period_r is never 0 while RUN, so this never underflows where it is used
    assign last_cnt  = period_r - cnt_one;
    assign busy      = (state == RUN);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pre_cnt  <= '0;
            period_r <= '0;
            pre_r    <= '0;
            reload_r <= 1'b0;
            tick     <= 1'b0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pre_cnt  <= pre_cnt_n;
            period_r <= period_n;
            pre_r    <= pre_n;
            reload_r <= reload_n;
            tick     <= tick_n;
            done     <= done_n;
            cfg_err  <= err_n;
        end
    end

    // Priority per edge: stop, then start (accept or reject), then counting.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pre_cnt_n = pre_cnt;
        period_n  = period_r;
        pre_n     = pre_r;
        reload_n  = reload_r;
        tick_n    = 1'b0;
        done_n    = 1'b0;
        err_n     = 1'b0;

        if (stop) begin
            if (state == RUN) begin
                state_n   = IDLE;
                cnt_n     = '0;
                pre_cnt_n = '0;
            end
        end else if (start) begin
            if (period != '0) begin
                period_n  = period;
                pre_n     = prescale;
                reload_n  = reload;
                cnt_n     = '0;
                pre_cnt_n = '0;
                state_n   = RUN;
            end else begin
                err_n   = 1'b1;
                state_n = IDLE;
            end
        end else if (state == RUN && en) begin
            if (pre_cnt != pre_r) begin
                pre_cnt_n = pre_cnt + pre_one;
            end else begin
                pre_cnt_n = '0;
                if (cnt != last_cnt) begin
                    cnt_n = cnt + cnt_one;
                end else begin
                    cnt_n  = '0;
                    tick_n = 1'b1;
                    if (!reload_r) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: per-cycle vector table plus hand-built
// sequences for long auto-reload and maximum-period intervals.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, en, reload;
    logic [7:0] period;
    logic [3:0] prescale;
    logic [7:0] cnt;
    logic       busy, tick, done, cfg_err, dbg_state;

    counter_sequencer #(.width(8), .pre_width(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en),
        .reload(reload), .period(period), .prescale(prescale),
        .cnt(cnt), .busy(busy), .tick(tick), .done(done),
        .cfg_err(cfg_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // {cnt, busy, tick, done, cfg_err}
    logic [11:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       s, p, e, r;
        logic [7:0] per;
        logic [3:0] ps;
        logic [7:0] c;
        logic       b, t, d, err;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [11:0] pack(input logic [7:0] c, input logic b, t, d, e);
        return {c, b, t, d, e};
    endfunction

    function automatic logic [7:0] rnd8();
        return 8'($urandom_range(0, 255));
    endfunction

    function automatic logic [3:0] rnd4();
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic add(input logic s, p, e, r, input logic [7:0] per, input logic [3:0] ps,
                       input logic [7:0] c, input logic b, t, d, err);
        vec_t v;
        v.s = s; v.p = p; v.e = e; v.r = r; v.per = per; v.ps = ps;
        v.c = c; v.b = b; v.t = t; v.d = d; v.err = err;
        vecs.push_back(v);
    endtask

    // Idle-cycle row with random configuration, which must be ignored.
    task automatic add_run(input logic e, input logic [7:0] c, input logic b, t, d);
        add(1'b0, 1'b0, e, 1'($urandom_range(0, 1)), rnd8(), rnd4(), c, b, t, d, 1'b0);
    endtask

    task automatic check(input string name);
        logic [11:0] e, a;
        e = exp_q.pop_front();
        a = {cnt, busy, tick, done, cfg_err};
        n_tests++;
        if (a !== e || dbg_state !== e[3]) begin
            n_fail++;
            $display("FAIL %s: got cnt=%0d busy=%b tick=%b done=%b err=%b st=%b, want cnt=%0d busy=%b tick=%b done=%b err=%b",
                     name, a[11:4], a[3], a[2], a[1], a[0], dbg_state, e[11:4], e[3], e[2], e[1], e[0]);
        end
    endtask

    // Drive inputs, take one edge, push the expectation, compare just after the edge.
    task automatic step(input logic s, p, e, r, input logic [7:0] per, input logic [3:0] ps,
                        input logic [11:0] exp, input string name);
        start = s; stop = p; en = e; reload = r; period = per; prescale = ps;
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
        check(name);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0; reload = 1'b0;
        period = 8'd0; prescale = 4'd0;

        // One-shot, period 5
        add(1,0,1,0,8'd5,4'd0, 8'd0,1,0,0,0);
        for (int k = 1; k <= 4; k++) add_run(1'b1, 8'(k), 1'b1, 1'b0, 1'b0);
        add_run(1'b1, 8'd0, 1'b0, 1'b1, 1'b1);
        add_run(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        // Enable gating, period 4, en low for 3 cycles at cnt=2
        add(1,0,1,0,8'd4,4'd0, 8'd0,1,0,0,0);
        add_run(1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
        add_run(1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) add_run(1'b0, 8'd2, 1'b1, 1'b0, 1'b0);
        add_run(1'b1, 8'd3, 1'b1, 1'b0, 1'b0);
        add_run(1'b1, 8'd0, 1'b0, 1'b1, 1'b1);
        // Stop on the terminal edge
        add(1,0,1,0,8'd3,4'd0, 8'd0,1,0,0,0);
        add_run(1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
        add_run(1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
        add(0,1,1,0,8'd3,4'd0, 8'd0,0,0,0,0);
        // Stop and start together in RUN
        add(1,0,1,0,8'd3,4'd0, 8'd0,1,0,0,0);
        add_run(1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
        add(1,1,1,0,8'd5,4'd0, 8'd0,0,0,0,0);
        // Stop in IDLE has no effect
        add(0,1,1,0,8'd5,4'd0, 8'd0,0,0,0,0);
        // Restart at cnt=6 of period 10 with a new period of 4
        add(1,0,1,0,8'd10,4'd0, 8'd0,1,0,0,0);
        for (int k = 1; k <= 6; k++) add_run(1'b1, 8'(k), 1'b1, 1'b0, 1'b0);
        add(1,0,1,0,8'd4,4'd0, 8'd0,1,0,0,0);
        for (int k = 1; k <= 3; k++) add_run(1'b1, 8'(k), 1'b1, 1'b0, 1'b0);
        add_run(1'b1, 8'd0, 1'b0, 1'b1, 1'b1);
        // Restart exactly on the terminal edge discards that tick
        add(1,0,1,0,8'd2,4'd0, 8'd0,1,0,0,0);
        add_run(1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
        add(1,0,1,0,8'd3,4'd0, 8'd0,1,0,0,0);
        add_run(1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
        add_run(1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
        add_run(1'b1, 8'd0, 1'b0, 1'b1, 1'b1);
        // cfg_err in IDLE
        add(1,0,1,0,8'd0,4'd3, 8'd0,0,0,0,1);
        add_run(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        // cfg_err in RUN
        add(1,0,1,0,8'd3,4'd0, 8'd0,1,0,0,0);
        add(1,0,1,1,8'd0,4'd0, 8'd0,0,0,0,1);
        add_run(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        // Period 1 auto-reload ticks every cycle
        add(1,0,1,1,8'd1,4'd0, 8'd0,1,0,0,0);
        for (int k = 0; k < 4; k++) add_run(1'b1, 8'd0, 1'b1, 1'b1, 1'b0);
        add(0,1,1,1,8'd1,4'd0, 8'd0,0,0,0,0);

        // Reset: async clear, including mid-interval
        #2;
        n_tests++;
        if ({cnt, busy, tick, done, cfg_err, dbg_state} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_init: got cnt=%0d busy=%b tick=%b done=%b err=%b, want all 0",
                     cnt, busy, tick, done, cfg_err);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        step(1,0,1,0,8'd5,4'd0, pack(8'd0,1,0,0,0), "pre_rst_start");
        step(0,0,1,0,8'd5,4'd0, pack(8'd1,1,0,0,0), "pre_rst_cnt1");
        step(0,0,1,0,8'd5,4'd0, pack(8'd2,1,0,0,0), "pre_rst_cnt2");
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({cnt, busy, tick, done, cfg_err, dbg_state} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_async: got cnt=%0d busy=%b tick=%b done=%b err=%b, want all 0",
                     cnt, busy, tick, done, cfg_err);
        end
        @(negedge clk);
        rst = 1'b0;
        step(0,0,1,0,8'd5,4'd0, pack(8'd0,0,0,0,0), "post_rst_idle");

        // Table
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].s, vecs[i].p, vecs[i].e, vecs[i].r, vecs[i].per, vecs[i].ps,
                 pack(vecs[i].c, vecs[i].b, vecs[i].t, vecs[i].d, vecs[i].err),
                 $sformatf("vec[%0d]", i));
        end

        // Auto-reload period 3, prescale 2: a step every 3 edges, tick every 9
        step(1,0,1,1,8'd3,4'd2, pack(8'd0,1,0,0,0), "ar_start");
        for (int k = 1; k <= 40; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), rnd8(), rnd4(),
                 pack(8'((k / 3) % 3), 1'b1, (k % 9) == 0, 1'b0, 1'b0),
                 $sformatf("ar_k%0d", k));
        end
        step(0,1,1,1,8'd3,4'd2, pack(8'd0,0,0,0,0), "ar_stop");

        // Maximum period: 255 edges to the one-shot tick, no wrap
        step(1,0,1,0,8'd255,4'd0, pack(8'd0,1,0,0,0), "p255_start");
        for (int k = 1; k <= 255; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), rnd8(), rnd4(),
                 (k < 255) ? pack(8'(k), 1'b1, 1'b0, 1'b0, 1'b0) : pack(8'd0, 1'b0, 1'b1, 1'b1, 1'b0),
                 $sformatf("p255_k%0d", k));
        end
        step(0,0,1,0,8'd9,4'd0, pack(8'd0,0,0,0,0), "p255_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Programmable interval controller that sequences a free-running enable-gated up-counter into one-shot or auto-reload timing intervals.
- It latches a period and prescale configuration on start and runs a RUN/IDLE state machine.
- It emits a single-cycle tick at each interval expiry and a done pulse when a one-shot finishes.
- It sits between a control/CSR source and any datapath that needs periodic strobes.

Parameters:
- width, 8: counter and period width in bits.
- pre_width, 4: prescaler width in bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  level sampled each edge; requests interval start or restart.
- stop  in  1  level sampled each edge; aborts a running interval.
- en  in  1  count enable; 0 freezes prescaler and counter in RUN.
- reload  in  1  mode, latched on accepted start: 1 = auto-reload, 0 = one-shot.
- period  in  width  interval length in counter steps, latched on accepted start.
- prescale  in  pre_width  extra cycles per counter step, latched on accepted start.
- cnt  out  width  current counter value (registered).
- busy  out  1  1 while in RUN (registered).
- tick  out  1  one-cycle pulse on each interval expiry (registered).
- done  out  1  one-cycle pulse when a one-shot interval completes (registered).
- cfg_err  out  1  one-cycle pulse when a start is rejected because period == 0.

Behaviour:
- Reset (async, any time including mid-interval):
  - state IDLE; cnt = 0; busy = tick = done = cfg_err = 0.
  - Latched period_r, pre_r, reload_r and prescaler pre_cnt cleared to 0.
- tick, done and cfg_err default to 0 every edge; each is high for exactly one cycle when set.
- Priority per edge: stop > start > counting.
- IDLE state:
  - start=1, period != 0: latch period_r/pre_r/reload_r; cnt = 0, pre_cnt = 0; go to RUN (busy=1 after the same edge).
  - start=1, period == 0: cfg_err = 1; stay in IDLE; cnt is unchanged.
  - stop in IDLE: no effect. en in IDLE: ignored.
- RUN state:
  - stop=1: go to IDLE; cnt = 0, pre_cnt = 0; no tick or done, even if the terminal count coincides.
  - start=1 (no stop): restart. Apply the same latch/clear rules as IDLE; a period of 0 gives cfg_err=1 and goes to IDLE. The terminal step on that edge is discarded.
  - en=0: cnt and pre_cnt hold.
  - en=1 and pre_cnt != pre_r: pre_cnt = pre_cnt + 1.
  - en=1 and pre_cnt == pre_r (a step): pre_cnt = 0.
    - If cnt != period_r - 1: cnt = cnt + 1.
    - If cnt == period_r - 1 (terminal): tick = 1 and cnt = 0. With reload_r=1, stay in RUN. With reload_r=0, done = 1 and go to IDLE (busy=0 on the same edge).
- Timing: with en held 1, the interval is period_r*(pre_r+1) cycles. The first tick appears that many edges after the edge that accepted start.
- Arithmetic:
  - period_r - 1 is computed in width bits; period_r never equals 0 in RUN.
  - The maximum period is 2^width - 1. cnt never exceeds period_r - 1, so it never wraps.
  - pre_cnt compares in pre_width bits; prescale = 0 means one step per enabled cycle.
- Configuration inputs (period, prescale, reload) are sampled only on an accepted start. Changes at other times have no effect.

Test Plan:
- Reset and one-shot: assert rst mid-cycle, then release; start with period=5, prescale=0, reload=0, en=1.
  - cnt, busy and pulses are 0 asynchronously during reset.
  - After start, cnt goes 0,1,2,3,4,0. tick and done are both high for 1 cycle exactly 5 edges after start; busy then falls.
- Auto-reload with prescale: period=3, prescale=2, reload=1, en=1 for 40 cycles.
  - tick pulses every 9 cycles; cnt advances every 3rd cycle; done stays 0; busy stays 1.
- Enable gating: period=4, prescale=0, reload=0; drop en for 3 cycles at cnt=2.
  - cnt holds at 2 for 3 cycles; tick is delayed by exactly 3 cycles (7 edges after start).
- Stop and priority:
  - stop asserted on the terminal edge (cnt=period-1, step due): no tick, no done; state IDLE, cnt=0.
  - stop and start together in RUN: result is IDLE.
- Restart and cfg_err:
  - start again at cnt=6 of period=10: cnt goes to 0 with new config, and no tick is emitted on that edge.
  - start with period=0 in IDLE: one cfg_err pulse, busy stays 0.
  - start with period=0 in RUN: one cfg_err pulse, busy falls.
- Boundaries:
  - period=1, prescale=0, reload=1: tick is high on every cycle after start and cnt stays 0.
  - period=255, width=8: tick arrives after 255 cycles with no cnt overflow.
